// File: rtl/muldiv_seq.sv
// Sequential MIPS HI/LO unit for MULT/MULTU/DIV/DIVU. It uses one shared 32-bit adder
// and takes 36 cycles from the accept cycle to the done pulse, whatever the operands.
module add_sub_32b (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        c_in,
  output logic [31:0] sum
);
  assign sum = x + y + {31'd0, c_in};
endmodule

// state | meaning
// IDLE  | waiting; on start latch op/b and |src_a| (negated through the adder)
// PREP  | replace a negative signed divisor/multiplier with its magnitude
// CALC  | ITER shift-add (MULT) or restoring-subtract (DIV) iterations
// FIX1  | signed fixup of LO (product low half / quotient)
// FIX2  | signed fixup of HI (product high half / remainder)
// DONE  | done pulse; hi/lo valid
module muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX1, FIX2, DONE} state_t;
  state_t state, state_nxt;

  logic [1:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          neg_q, neg_r, b_zero, lo_zero;
  logic [CW-1:0] cnt;

  logic          is_signed, is_div, first;
  logic [31:0]   hi_cur, lo_cur, hs, msum;
  logic          hs_top, qbit, mbit;
  logic [31:0]   add_x, add_y, add_sum;
  logic          add_cin, carry;

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];

  // The first CALC iteration works on the initial {0, operand} pair, so hi/lo
  // keep the previous result until real iterations begin.
  assign first  = (cnt == CW'(ITER - 1));
  assign hi_cur = first ? 32'd0 : hi;
  assign lo_cur = first ? (is_div ? a_q : b_q) : lo;
  assign hs_top = hi_cur[31];
  assign hs     = {hi_cur[30:0], lo_cur[31]};

  always_comb begin
    add_x   = 32'd0;
    add_y   = 32'd0;
    add_cin = 1'b0;
    case (state)
      IDLE: begin
        add_y   = ~src_a;
        add_cin = 1'b1;
      end
      PREP: begin
        add_y   = ~b_q;
        add_cin = 1'b1;
      end
      CALC: begin
        if (is_div) begin
          add_x   = hs;
          add_y   = ~b_q;
          add_cin = 1'b1;
        end else begin
          add_x = hi_cur;
          add_y = a_q;
        end
      end
      FIX1: begin
        add_y   = ~lo;
        add_cin = 1'b1;
      end
      FIX2: begin
        if (is_div) begin
          add_y   = ~hi;
          add_cin = 1'b1;
        end else begin
          add_x   = ~hi;
          add_cin = lo_zero;
        end
      end
      default: ;
    endcase
  end

  add_sub_32b u_add (
    .x    (add_x),
    .y    (add_y),
    .c_in (add_cin),
    .sum  (add_sum)
  );

  assign carry = (add_x[31] & add_y[31]) | ((add_x[31] ^ add_y[31]) & ~add_sum[31]);
  assign qbit  = hs_top | carry;
  assign mbit  = lo_cur[0] & carry;
  assign msum  = lo_cur[0] ? add_sum : hi_cur;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = FIX1;
      FIX1:    state_nxt = FIX2;
      FIX2:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= 2'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      lo_zero     <= 1'b0;
      cnt         <= '0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q        <= op;
          a_q         <= (~op[0] & src_a[31]) ? add_sum : src_a;
          b_q         <= src_b;
          neg_q       <= ~op[0] & (src_a[31] ^ src_b[31]);
          neg_r       <= ~op[0] & src_a[31];
          div_by_zero <= 1'b0;
        end
        PREP: begin
          if (is_signed & b_q[31]) b_q <= add_sum;
          b_zero <= (b_q == 32'd0);
          cnt    <= CW'(ITER - 1);
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            hi <= qbit ? add_sum : hs;
            lo <= {lo_cur[30:0], qbit};
          end else begin
            hi <= {mbit, msum[31:1]};
            lo <= {msum[0], lo_cur[31:1]};
          end
        end
        FIX1: begin
          lo_zero <= (lo == 32'd0);
          if (is_signed & neg_q & ~(is_div & b_zero)) lo <= add_sum;
        end
        FIX2: begin
          // A zero divisor leaves |a| in HI; restoring the sign returns src_a unchanged.
          if (is_signed & (is_div ? neg_r : neg_q)) hi <= add_sum;
          div_by_zero <= is_div & b_zero;
        end
        default: ;
      endcase
    end
  end
endmodule
